dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter that shares the single-port data memory between the pipelined CPU's MEM stage and an external DMA/loader requester. The CPU has fixed priority. The DMA port receives idle memory cycles, and a starvation counter guarantees it a forced slot, during which the CPU pipeline is stalled. The block sits between the EX/MEM pipeline register outputs and DATAMEM. Memory read is combinational and memory write occurs on the rising Clk edge.

## Interface
- STARVE_LIMIT, 8: consecutive denied DMA cycles before a forced DMA slot; legal range 1..255.
- Clk  input  1  clock; all state updates on rising edge.
- Clrn  input  1  reset, asynchronous, active-low.
- En  input  1  global enable; 0 freezes all state and blocks memory writes.
- cpu_req  input  1  MEM stage needs memory this cycle (load or store).
- cpu_wr  input  1  CPU store (M_Wmem).
- cpu_addr  input  32  CPU address (M_R).
- cpu_wdata  input  32  CPU store data (M_S).
- cpu_rdata  output  32  load data to MEM/WB; equals mem_rdata.
- cpu_stall  output  1  freeze the whole pipeline, including EX/MEM, for this cycle.
- dma_req  input  1  DMA request; must be held stable with its attributes until dma_gnt.
- dma_wr  input  1  DMA write when 1, read when 0.
- dma_addr  input  32  DMA address.
- dma_wdata  input  32  DMA write data.
- dma_gnt  output  1  combinational; access performed this cycle.
- dma_rdata  output  32  registered read data.
- dma_rvalid  output  1  one-cycle pulse, the cycle after a granted DMA read.
- mem_addr  output  32  to DATAMEM.
- mem_wdata  output  32  to DATAMEM.
- mem_we  output  1  to DATAMEM write enable.
- mem_rdata  input  32  from DATAMEM.

## Operation
- The block has two states, NORMAL and FORCE, plus a starvation counter cnt of 8 bits.
- Behaviour in NORMAL:
  - cpu_req=1: memory is driven by the CPU (mem_we=cpu_wr & En), and dma_gnt=0.
  - cpu_req=0 and dma_req=1: memory is driven by the DMA (mem_we=dma_wr & En), and dma_gnt=En.
  - Neither request: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=0.
  - cpu_stall=0.
- Counter in NORMAL, on enabled edges:
  - A denied cycle is one with dma_req=1 and cpu_req=1. On a denied cycle, cnt increments.
  - If a denied cycle brings cnt to STARVE_LIMIT, the next state is FORCE.
  - cnt clears on a grant, or when dma_req=0.
- Behaviour in FORCE:
  - Memory is driven by the DMA, and dma_gnt=dma_req & En.
  - cpu_stall=cpu_req.
  - The CPU must not write: mem_we=dma_wr & dma_req & En.
  - On the next enabled edge: cnt=0 and state returns to NORMAL.
  - If dma_req was dropped (protocol violation), no access occurs. There is still no write, and the block still returns to NORMAL.
- After FORCE, the CPU is served first again. The worst-case DMA wait is STARVE_LIMIT denied cycles; the grant comes on the following cycle.
- DMA read: on a granted read edge, dma_rdata<=mem_rdata and dma_rvalid<=1. Otherwise dma_rvalid<=0 and dma_rdata holds.
- cpu_rdata=mem_rdata always. Its value during a FORCE stall is don't-care to the CPU.
- When En=0:
  - State, cnt, dma_rdata and dma_rvalid hold.
  - mem_we=0 and dma_gnt=0.
  - Combinational muxing continues.

## Timing
- Reset values:
  - State NORMAL, cnt=0.
  - dma_rdata=0, dma_rvalid=0.
  - cpu_stall=0 and dma_gnt=0 while Clrn=0, because requests are masked during reset.
  - Reset is asynchronous, so it takes effect immediately, including mid-FORCE.
- Latencies:
  - DMA write: completes at the edge that ends the grant cycle.
  - DMA read: data is valid one cycle after grant (dma_rvalid pulse).
  - CPU: zero added latency outside FORCE.
- Simultaneous events:
  - cpu_req and dma_req together in NORMAL: the CPU wins.
  - A FORCE entry edge with En=0: the transition is deferred until En=1.
- A requester may change dma_req and its attributes on the edge after dma_gnt=1. Back-to-back DMA grants are allowed whenever the CPU is idle.

## Test plan
- Reset: assert Clrn=0 mid-FORCE -> cpu_stall=0, dma_gnt=0 and dma_rvalid=0 immediately; after release, state NORMAL and cnt=0.
- DMA write, CPU idle: dma_req=1, dma_wr=1, addr 0x40, data 0xDEADBEEF -> dma_gnt=1 and mem_we=1 the same cycle. A later CPU load of 0x40 returns 0xDEADBEEF on cpu_rdata.
- DMA read: memory word 0x44=0x12345678, DMA read with the CPU idle -> dma_gnt=1 in cycle t; dma_rvalid=1 and dma_rdata=0x12345678 in t+1; dma_rvalid=0 in t+2.
- Starvation, STARVE_LIMIT=8: cpu_req=1 continuously, DMA write held -> dma_gnt=0 for 8 cycles. Cycle 9: cpu_stall=1, dma_gnt=1 and mem_addr=dma_addr. Cycle 10: cpu_stall=0 and CPU drives memory.
- En freeze: same contention, with En=0 for 3 cycles after 5 denials -> cnt holds at 5 and mem_we=0; FORCE occurs 3 enabled denials after En returns.
- CPU store vs DMA in FORCE: cpu_wr=1 at 0x80 during FORCE -> the CPU write is suppressed; the store is performed the following cycle after the stall releases.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU MEM stage has fixed priority, the DMA port uses idle cycles,
// and a starvation counter forces one DMA slot (with a CPU pipeline stall) after repeated denials.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        En,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cpu_req_m;
    logic               dma_req_m;
    logic               dma_sel;

    assign cpu_rdata = mem_rdata;

    // Ownership, strobes and next-state; requests are masked while in reset.
    always_comb begin
        cpu_req_m = cpu_req & Clrn;
        dma_req_m = dma_req & Clrn;
        cnt_inc   = cnt + CNT_W'(1);
        dma_sel   = 1'b0;
        mem_we    = 1'b0;
        dma_gnt   = 1'b0;
        cpu_stall = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;

        case (state)
            ST_FORCE: begin
                dma_sel   = 1'b1;
                dma_gnt   = dma_req_m & En;
                cpu_stall = cpu_req_m;
                mem_we    = dma_wr & dma_req_m & En;
                state_nxt = ST_NORMAL;
                cnt_nxt   = '0;
            end
            default: begin
                if (cpu_req_m) begin
                    mem_we = cpu_wr & En;
                    if (dma_req_m) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
                            state_nxt = ST_FORCE;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end else if (dma_req_m) begin
                    dma_sel = 1'b1;
                    mem_we  = dma_wr & En;
                    dma_gnt = En;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = '0;
                end
            end
        endcase

        mem_addr  = dma_sel ? dma_addr  : cpu_addr;
        mem_wdata = dma_sel ? dma_wdata : cpu_wdata;
    end

    // State, starvation counter and DMA read-return registers; En=0 freezes everything.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state      <= ST_NORMAL;
            cnt        <= '0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else if (En) begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dma_rvalid <= dma_gnt & ~dma_wr;
            if (dma_gnt && !dma_wr) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus constrained-random traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 8;

    logic        Clk = 1'b0;
    logic        Clrn, En;
    logic        cpu_req, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int total = 0;
    int bad   = 0;

    // DATAMEM emulation: combinational read, write on rising edge.
    logic [31:0] ram [256];
    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge Clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .Clk(Clk), .Clrn(Clrn), .En(En),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Reference model: consecutive-denial count, pending forced slot, read return, memory image.
    int          m_waits;
    bit          m_forced;
    logic [31:0] m_rdata;
    bit          m_rvalid;
    logic [31:0] ref_mem [256];

    logic        e_gnt, e_stall, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;

    function automatic void model_reset();
        m_waits  = 0;
        m_forced = 1'b0;
        m_rdata  = 32'h0;
        m_rvalid = 1'b0;
    endfunction

    function automatic void model_outputs();
        bit c, d, dma_owns;
        c        = cpu_req && Clrn;
        d        = dma_req && Clrn;
        dma_owns = m_forced || (!c && d);
        e_addr   = dma_owns ? dma_addr  : cpu_addr;
        e_wdata  = dma_owns ? dma_wdata : cpu_wdata;
        e_gnt    = En && d && dma_owns;
        e_we     = En && (dma_owns ? (d && dma_wr) : (c && cpu_wr));
        e_stall  = m_forced && c;
        e_rdata  = ref_mem[e_addr[9:2]];
    endfunction

    task automatic tick();
        bit c, d;
        model_outputs();
        c = cpu_req && Clrn;
        d = dma_req && Clrn;
        if (Clrn && En) begin
            if (e_gnt && !dma_wr) begin
                m_rdata  = e_rdata;
                m_rvalid = 1'b1;
            end else begin
                m_rvalid = 1'b0;
            end
            if (m_forced) begin
                m_forced = 1'b0;
                m_waits  = 0;
            end else if (c && d) begin
                m_waits = m_waits + 1;
                if (m_waits == int'(LIMIT)) m_forced = 1'b1;
            end else begin
                m_waits = 0;
            end
        end
        if (e_we) ref_mem[e_addr[9:2]] = e_wdata;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Clrn = 1'b0; En = 1'b1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h4; dma_wdata = 32'h5;
        model_reset();
        @(negedge Clk);
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b exp=0", dma_gnt); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", dma_rvalid); end
        total++; if (dma_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", dma_rdata); end
        tick();
        Clrn = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
        tick();
    endtask

    task automatic test_dma_write();
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEADBEEF;
        @(negedge Clk);
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL dw_gnt got=%b exp=1", dma_gnt); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL dw_we got=%b exp=1", mem_we); end
        total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL dw_addr got=%h exp=40", mem_addr); end
        tick();
        dma_req = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h40;
        @(negedge Clk);
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL dw_load got=%h exp=deadbeef", cpu_rdata); end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_dma_read();
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h12345678;
        tick();
        cpu_req = 1'b0; cpu_wr = 1'b0;
        dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h44;
        @(negedge Clk);
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL dr_gnt got=%b exp=1", dma_gnt); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL dr_we got=%b exp=0", mem_we); end
        tick();
        dma_req = 1'b0;
        @(negedge Clk);
        total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL dr_rvalid1 got=%b exp=1", dma_rvalid); end
        total++; if (dma_rdata !== 32'h12345678) begin bad++; $display("FAIL dr_data got=%h exp=12345678", dma_rdata); end
        tick();
        @(negedge Clk);
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL dr_rvalid2 got=%b exp=0", dma_rvalid); end
        tick();
    endtask

    task automatic test_starvation();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0;
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h100; dma_wdata = 32'hA5A5A5A5;
        for (int i = 1; i <= int'(LIMIT); i++) begin
            @(negedge Clk);
            total++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
                bad++; $display("FAIL st_deny%0d gnt=%b stall=%b exp=0,0", i, dma_gnt, cpu_stall);
            end
            tick();
        end
        @(negedge Clk);
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL st_stall got=%b exp=1", cpu_stall); end
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL st_gnt got=%b exp=1", dma_gnt); end
        total++; if (mem_addr !== 32'h100 || mem_we !== 1'b1) begin
            bad++; $display("FAIL st_mem addr=%h we=%b exp=100,1", mem_addr, mem_we);
        end
        tick();
        dma_req = 1'b0;
        @(negedge Clk);
        total++; if (cpu_stall !== 1'b0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL st_release stall=%b addr=%h exp=0,0", cpu_stall, mem_addr);
        end
        tick();
    endtask

    task automatic test_en_freeze();
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h11111111;
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h24; dma_wdata = 32'h22222222;
        repeat (5) tick();
        En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++; if (mem_we !== 1'b0 || dma_gnt !== 1'b0) begin
                bad++; $display("FAIL en_off%0d we=%b gnt=%b exp=0,0", i, mem_we, dma_gnt);
            end
            tick();
        end
        En = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
                bad++; $display("FAIL en_deny%0d gnt=%b stall=%b exp=0,0", i, dma_gnt, cpu_stall);
            end
            tick();
        end
        @(negedge Clk);
        total++; if (cpu_stall !== 1'b1 || dma_gnt !== 1'b1) begin
            bad++; $display("FAIL en_force stall=%b gnt=%b exp=1,1", cpu_stall, dma_gnt);
        end
        tick();
        dma_req = 1'b0; cpu_wr = 1'b0;
        tick();
    endtask

    task automatic test_force_store();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0BADF00D;
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'hC0; dma_wdata = 32'hCAFEF00D;
        repeat (LIMIT) tick();
        cpu_wr = 1'b1; cpu_addr = 32'h80;
        @(negedge Clk);
        total++; if (cpu_stall !== 1'b1 || mem_addr !== 32'hC0 || mem_wdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL fs_dma stall=%b addr=%h data=%h exp=1,c0,cafef00d", cpu_stall, mem_addr, mem_wdata);
        end
        tick();
        total++; if (ram[32] !== 32'h0) begin bad++; $display("FAIL fs_suppress got=%h exp=0", ram[32]); end
        total++; if (ram[48] !== 32'hCAFEF00D) begin bad++; $display("FAIL fs_dmawr got=%h exp=cafef00d", ram[48]); end
        dma_req = 1'b0;
        @(negedge Clk);
        total++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h80) begin
            bad++; $display("FAIL fs_cpu stall=%b we=%b addr=%h exp=0,1,80", cpu_stall, mem_we, mem_addr);
        end
        tick();
        total++; if (ram[32] !== 32'h0BADF00D) begin bad++; $display("FAIL fs_store got=%h exp=0badf00d", ram[32]); end
        cpu_req = 1'b0; cpu_wr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_force();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h8;
        dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h44;
        repeat (LIMIT) tick();
        @(negedge Clk);
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rf_pre got=%b exp=1", cpu_stall); end
        #1 Clrn = 1'b0;
        #1;
        total++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0 || dma_rvalid !== 1'b0) begin
            bad++; $display("FAIL rf_async stall=%b gnt=%b rvalid=%b exp=0,0,0", cpu_stall, dma_gnt, dma_rvalid);
        end
        model_reset();
        @(posedge Clk);
        #1 Clrn = 1'b1;
        for (int i = 1; i <= int'(LIMIT); i++) begin
            @(negedge Clk);
            total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rf_deny%0d got=%b exp=0", i, dma_gnt); end
            tick();
        end
        @(negedge Clk);
        total++; if (cpu_stall !== 1'b1 || dma_gnt !== 1'b1) begin
            bad++; $display("FAIL rf_force stall=%b gnt=%b exp=1,1", cpu_stall, dma_gnt);
        end
        tick();
        dma_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit last_gnt;
        for (int n = 0; n < 400; n++) begin
            @(negedge Clk);
            model_outputs();
            total++; if (dma_gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, dma_gnt, e_gnt); end
            total++; if (cpu_stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, cpu_stall, e_stall); end
            total++; if (mem_we !== e_we) begin bad++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, mem_we, e_we); end
            total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, mem_addr, e_addr); end
            total++; if (mem_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata, e_wdata); end
            total++; if (cpu_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, cpu_rdata, e_rdata); end
            total++; if (dma_rvalid !== m_rvalid) begin bad++; $display("FAIL rnd_rvalid n=%0d got=%b exp=%b", n, dma_rvalid, m_rvalid); end
            total++; if (dma_rdata !== m_rdata) begin bad++; $display("FAIL rnd_drdata n=%0d got=%h exp=%h", n, dma_rdata, m_rdata); end
            last_gnt = e_gnt;
            tick();
            En        = ($urandom_range(0, 9) != 0);
            cpu_req   = ($urandom_range(0, 9) < 7);
            cpu_wr    = $urandom_range(0, 1) == 1;
            cpu_addr  = 32'($urandom_range(0, 15)) << 2;
            cpu_wdata = $urandom;
            if (!dma_req || last_gnt) begin
                dma_req   = ($urandom_range(0, 2) != 0);
                dma_wr    = $urandom_range(0, 1) == 1;
                dma_addr  = 32'($urandom_range(0, 15)) << 2;
                dma_wdata = $urandom;
            end
        end
        En = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_dma_write();
        test_dma_read();
        test_starvation();
        test_en_freeze();
        test_force_store();
        test_reset_mid_force();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
